// File: rtl/fifo_stim_pkg.sv
// fifo_stim_pkg
//   Shared definitions for the FIFO legal-traffic stimulus generator:
//   FSM state encoding, LFSR width and Galois tap mask, and a one-step
//   LFSR helper.
//   No ports (package).

`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

package fifo_stim_pkg;

  localparam int unsigned      LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    INJECT,
    POST,
    DRAIN,
    DONE
  } state_e;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/fifo_stim_gen_lfsr16.sv
// lfsr16
//   16-bit Galois LFSR (taps 16'hB400) with synchronous active-low load
//   of SEED and an advance enable.
//   Ports:
//     clk_i    clock
//     rst_ni   synchronous active-low reset; loads SEED
//     en_i     advance one step this cycle
//     state_o  current LFSR state

module lfsr16
  import fifo_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/fifo_stim_gen.sv
// fifo_stim_gen
//   Legal-traffic transmitter for a single-FIFO scoreboard harness.
//   Pushes LFSR background data, injects exactly one magic packet (flagged
//   by a single-cycle start), pushes POST_PUSHES more background words and
//   then drains the FIFO. Never pushes while full or pops while empty;
//   background data is never equal to the magic value.
//   Ports:
//     clk           clock
//     rst           synchronous active-low reset
//     go            level; starts a run from IDLE, DONE returns to IDLE when low
//     inject_after  background pushes before the magic packet
//     magic_value   magic payload, sampled when go is taken
//     full, empty   FIFO status
//     push, pop     FIFO controls (already gated by full/empty)
//     data_out      FIFO write data
//     start         high on the accepted magic push only
//     busy          high in PRE/INJECT/POST/DRAIN
//     done          high in DONE

module fifo_stim_gen
  import fifo_stim_pkg::*;
#(
  parameter int unsigned       WIDTH       = `FIFO_DWIDTH,
  parameter int unsigned       DEPTH       = `FIFO_DEPTH,
  parameter int unsigned       CNTW        = 8,
  parameter int unsigned       POST_PUSHES = 4,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CNTW-1:0]  inject_after,
  input  logic [WIDTH-1:0] magic_value,
  input  logic             full,
  input  logic             empty,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             start,
  output logic             busy,
  output logic             done
);

  localparam logic [CNTW:0] POST_TGT  = (CNTW+1)'(POST_PUSHES);
  localparam bit            POST_NONE = (POST_PUSHES == 0);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNTW-1:0]   post_cnt_q, post_cnt_d;
  logic [WIDTH-1:0]  magic_q, magic_d;
  logic [LFSR_W-1:0] lfsr_q;

  logic              want_push;
  logic              want_pop;
  logic [WIDTH-1:0]  bg_raw;
  logic [WIDTH-1:0]  bg;
  logic [CNTW:0]     pre_next;
  logic [CNTW:0]     post_next;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (busy),
    .state_o (lfsr_q)
  );

  // Inverting on a collision keeps background words distinct from the
  // magic value without stalling the LFSR sequence.
  assign bg_raw = lfsr_q[WIDTH-1:0];
  assign bg     = (bg_raw == magic_q) ? ~bg_raw : bg_raw;

  // One extra bit so the compare against the target cannot alias on wrap.
  assign pre_next  = {1'b0, pre_cnt_q} + 1'b1;
  assign post_next = {1'b0, post_cnt_q} + 1'b1;

  // Output decode from the current state.
  always_comb begin
    want_push = 1'b0;
    want_pop  = 1'b0;
    data_out  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      PRE, POST: begin
        want_push = 1'b1;
        want_pop  = lfsr_q[LFSR_W-1];
        data_out  = bg;
        busy      = 1'b1;
      end
      INJECT: begin
        want_push = 1'b1;
        data_out  = magic_q;
        busy      = 1'b1;
      end
      DRAIN: begin
        want_pop  = 1'b1;
        data_out  = bg;
        busy      = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign push  = want_push & ~full;
  assign pop   = want_pop & ~empty;
  assign start = push & (state_q == INJECT);

  // Next-state and counter update; kept apart from the output decode so
  // the transitions can consume the gated push without a comb loop.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    magic_d    = magic_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          magic_d    = magic_value;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          state_d    = (inject_after == '0) ? INJECT : PRE;
        end
      end
      PRE: begin
        if (push) begin
          if (!(&pre_cnt_q)) begin
            pre_cnt_d = pre_next[CNTW-1:0];
          end
          if (pre_next == {1'b0, inject_after}) begin
            state_d = INJECT;
          end
        end
      end
      INJECT: begin
        if (push) begin
          state_d = POST_NONE ? DRAIN : POST;
        end
      end
      POST: begin
        if (push) begin
          if (!(&post_cnt_q)) begin
            post_cnt_d = post_next[CNTW-1:0];
          end
          if (post_next == POST_TGT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!go) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      magic_q    <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      magic_q    <= magic_d;
    end
  end

  // LFSR bits above the data width (other than the pop bit) and the depth
  // parameter have no consumer here; fold them into a named sink.
  logic unused_sink;
  assign unused_sink = ^{lfsr_q, DEPTH[0]};

endmodule
